// File: rtl/clock_enable_gen.sv
// Multi-channel clock divider producing registered divided clocks and
// single-cycle enable strobes, with glitch-free runtime ratio changes and phase sync.
module clock_enable_gen #(
    parameter int NCH         = 4,
    parameter int W           = 16,
    parameter int DIV_DEFAULT = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NCH*W-1:0]   div_i,
    input  logic               load_i,
    input  logic               sync_i,
    output logic [NCH-1:0]     clk_o,
    output logic [NCH-1:0]     ce_o,
    output logic [NCH-1:0]     pend_o
);

    localparam logic [W-1:0] DIV_INIT = W'(DIV_DEFAULT);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [W-1:0] a_q, a_d;
        logic [W-1:0] p_q, p_d;
        logic         f_q, f_d;
        logic [W-1:0] c_q, c_d;
        logic         clk_q, clk_d;
        logic         ce_q, ce_d;
        logic [W-1:0] div_k;
        logic [W:0]   half;
        logic         last;

        assign div_k = div_i[k*W +: W];
        // Computed one bit wider so the largest ratio does not wrap before halving.
        assign half  = ({1'b0, a_q} + 1'b1) >> 1;
        assign last  = (a_q != '0) && (c_q == a_q - 1'b1);

        always_comb begin
            a_d   = a_q;
            p_d   = p_q;
            f_d   = f_q;
            c_d   = c_q;
            clk_d = 1'b0;
            ce_d  = 1'b0;
            if (load_i && sync_i) begin
                a_d = div_k;
                c_d = '0;
                f_d = 1'b0;
            end else begin
                if (sync_i) begin
                    c_d = '0;
                    if (f_q) begin
                        a_d = p_q;
                        f_d = 1'b0;
                    end
                end else if (a_q == '0) begin
                    c_d = '0;
                    if (f_q) begin
                        a_d = p_q;
                        f_d = 1'b0;
                    end
                end else begin
                    clk_d = ({1'b0, c_q} < half);
                    ce_d  = last;
                    if (last) begin
                        c_d = '0;
                        if (f_q) begin
                            a_d = p_q;
                            f_d = 1'b0;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
                // A load landing on a boundary re-arms pending after the old value is applied.
                if (load_i) begin
                    p_d = div_k;
                    f_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                a_q   <= DIV_INIT;
                p_q   <= '0;
                f_q   <= 1'b0;
                c_q   <= '0;
                clk_q <= 1'b0;
                ce_q  <= 1'b0;
            end else begin
                a_q   <= a_d;
                p_q   <= p_d;
                f_q   <= f_d;
                c_q   <= c_d;
                clk_q <= clk_d;
                ce_q  <= ce_d;
            end
        end

        assign clk_o[k]  = clk_q;
        assign ce_o[k]   = ce_q;
        assign pend_o[k] = f_q;
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Self-checking bench for clock_enable_gen: directed scenarios plus random
// traffic, all compared against a period-position reference model.
module tb_clock_enable_gen;

  localparam int NCH = 4;
  localparam int W = 16;
  localparam int DIV_DEFAULT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NCH*W-1:0] div = '0;
  logic load = 1'b0;
  logic sync = 1'b0;
  logic [NCH-1:0] clk_o, ce_o, pend_o;

  int checks = 0;
  int errors = 0;

  clock_enable_gen #(.NCH(NCH), .W(W), .DIV_DEFAULT(DIV_DEFAULT)) dut (
    .clk(clk), .reset_n(reset_n), .div_i(div), .load_i(load), .sync_i(sync),
    .clk_o(clk_o), .ce_o(ce_o), .pend_o(pend_o)
  );

  always #5 clk = ~clk;

  // Reference model: each channel tracks its position inside the current period.
  int m_ratio[NCH], m_pend[NCH], m_pos[NCH];
  bit m_flag[NCH];
  logic [NCH-1:0] e_clk, e_ce, e_pend;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        m_ratio[k] = DIV_DEFAULT; m_pend[k] = 0; m_pos[k] = 0; m_flag[k] = 0;
      end
      e_clk = '0; e_ce = '0; e_pend = '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        int d;
        bit boundary;
        d = int'(div[k*W +: W]);
        boundary = 0;
        if (load && sync) begin
          m_ratio[k] = d; m_pos[k] = 0; m_flag[k] = 0;
          e_clk[k] = 0; e_ce[k] = 0;
        end else begin
          if (sync) begin
            m_pos[k] = 0; e_clk[k] = 0; e_ce[k] = 0; boundary = 1;
          end else if (m_ratio[k] == 0) begin
            e_clk[k] = 0; e_ce[k] = 0; boundary = 1;
          end else begin
            e_clk[k] = (2 * m_pos[k] < m_ratio[k]);
            e_ce[k] = (m_pos[k] + 1 == m_ratio[k]);
            m_pos[k] = (m_pos[k] + 1) % m_ratio[k];
            boundary = (m_pos[k] == 0);
          end
          if (boundary && m_flag[k]) begin
            m_ratio[k] = m_pend[k]; m_flag[k] = 0; m_pos[k] = 0;
          end
          if (load) begin
            m_pend[k] = d; m_flag[k] = 1;
          end
        end
        e_pend[k] = m_flag[k];
      end
    end
  end

  task automatic set_div(input int r0, input int r1, input int r2, input int r3);
    div[0*W +: W] = W'(r0);
    div[1*W +: W] = W'(r1);
    div[2*W +: W] = W'(r2);
    div[3*W +: W] = W'(r3);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({clk_o, ce_o, pend_o} !== '0) begin
      errors++;
      $display("FAIL reset_hold clk=%b ce=%b pend=%b expected all 0", clk_o, ce_o, pend_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic [NCH-1:0] pc, pe;
      @(negedge clk);
      pc = ((i % 4) < 2) ? '1 : '0;
      pe = ((i % 4) == 3) ? '1 : '0;
      checks++;
      if (clk_o !== pc || ce_o !== pe || pend_o !== '0) begin
        errors++;
        $display("FAIL reset_pattern cyc=%0d clk=%b/%b ce=%b/%b pend=%b/0000", i, clk_o, pc, ce_o, pe, pend_o);
      end
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    @(negedge clk);
    set_div(6, 1, 0, 3);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (clk_o !== e_clk || ce_o !== e_ce || pend_o !== e_pend) begin
        errors++;
        $display("FAIL load cyc=%0d clk=%b/%b ce=%b/%b pend=%b/%b", i, clk_o, e_clk, ce_o, e_ce, pend_o, e_pend);
      end
      @(negedge clk);
    end
    checks++;
    if (clk_o[1] !== 1'b1 || ce_o[1] !== 1'b1 || clk_o[2] !== 1'b0 || ce_o[2] !== 1'b0 || pend_o !== '0) begin
      errors++;
      $display("FAIL load_steady clk=%b ce=%b pend=%b expected ch1 1/1 ch2 0/0 pend 0000", clk_o, ce_o, pend_o);
    end
  endtask

  task automatic test_disabled();
    set_div(6, 1, 5, 3);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 25; i++) begin
      checks++;
      if (clk_o !== e_clk || ce_o !== e_ce || pend_o !== e_pend) begin
        errors++;
        $display("FAIL disabled cyc=%0d clk=%b/%b ce=%b/%b pend=%b/%b", i, clk_o, e_clk, ce_o, e_ce, pend_o, e_pend);
      end
      if (i == 1) begin
        checks++;
        if (clk_o[2] !== 1'b0 || pend_o[2] !== 1'b0) begin
          errors++;
          $display("FAIL disabled_adopt clk2=%b pend2=%b expected 0/0", clk_o[2], pend_o[2]);
        end
      end
      if (i == 2) begin
        checks++;
        if (clk_o[2] !== 1'b1) begin
          errors++;
          $display("FAIL disabled_first_high clk2=%b expected 1", clk_o[2]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_double_load();
    int run, runs_of_7;
    run = 0; runs_of_7 = 0;
    set_div(7, 1, 5, 3);
    load = 1'b1;
    @(negedge clk);
    set_div(9, 1, 5, 3);
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      checks++;
      if (clk_o !== e_clk || ce_o !== e_ce || pend_o !== e_pend) begin
        errors++;
        $display("FAIL double_load cyc=%0d clk=%b/%b ce=%b/%b pend=%b/%b", i, clk_o, e_clk, ce_o, e_ce, pend_o, e_pend);
      end
      if (clk_o[0]) run++;
      else begin
        if (run == 4) runs_of_7++;
        run = 0;
      end
      @(negedge clk);
    end
    checks++;
    if (runs_of_7 !== 0) begin
      errors++;
      $display("FAIL double_load_no7 high_runs_of_4=%0d expected 0", runs_of_7);
    end
  endtask

  task automatic test_sync();
    set_div(4, 6, 3, 2);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (10 + $urandom_range(0, 7)) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    checks++;
    if (clk_o !== '0 || ce_o !== '0) begin
      errors++;
      $display("FAIL sync_zero clk=%b ce=%b expected 0000/0000", clk_o, ce_o);
    end
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      checks++;
      if (clk_o !== e_clk || ce_o !== e_ce || pend_o !== e_pend) begin
        errors++;
        $display("FAIL sync cyc=%0d clk=%b/%b ce=%b/%b pend=%b/%b", i, clk_o, e_clk, ce_o, e_ce, pend_o, e_pend);
      end
      if (i == 1 || i == 12 || i == 24) begin
        checks++;
        if ((i == 1 && clk_o !== '1) || (i != 1 && ce_o !== '1)) begin
          errors++;
          $display("FAIL sync_align cyc=%0d clk=%b ce=%b expected all 1", i, clk_o, ce_o);
        end
      end
    end
  endtask

  task automatic test_load_sync();
    set_div(5, 5, 5, 5);
    load = 1'b1;
    sync = 1'b1;
    @(negedge clk);
    load = 1'b0;
    sync = 1'b0;
    checks++;
    if (clk_o !== '0 || ce_o !== '0 || pend_o !== '0) begin
      errors++;
      $display("FAIL load_sync_zero clk=%b ce=%b pend=%b expected 0", clk_o, ce_o, pend_o);
    end
    for (int i = 0; i < 10; i++) begin
      logic [NCH-1:0] pc, pe;
      @(negedge clk);
      pc = ((i % 5) < 3) ? '1 : '0;
      pe = ((i % 5) == 4) ? '1 : '0;
      checks++;
      if (clk_o !== pc || ce_o !== pe || pend_o !== '0) begin
        errors++;
        $display("FAIL load_sync cyc=%0d clk=%b/%b ce=%b/%b pend=%b/0000", i, clk_o, pc, ce_o, pe, pend_o);
      end
    end
  endtask

  task automatic test_async_reset();
    set_div(3, 7, 2, 9);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({clk_o, ce_o, pend_o} !== '0) begin
      errors++;
      $display("FAIL async_reset clk=%b ce=%b pend=%b expected all 0", clk_o, ce_o, pend_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (clk_o !== e_clk || ce_o !== e_ce || pend_o !== e_pend) begin
        errors++;
        $display("FAIL after_reset cyc=%0d clk=%b/%b ce=%b/%b pend=%b/%b", i, clk_o, e_clk, ce_o, e_ce, pend_o, e_pend);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NCH; k++) div[k*W +: W] = W'($urandom_range(0, 9));
      load = ($urandom_range(0, 15) == 0);
      sync = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      checks++;
      if (clk_o !== e_clk || ce_o !== e_ce || pend_o !== e_pend) begin
        errors++;
        $display("FAIL random cyc=%0d clk=%b/%b ce=%b/%b pend=%b/%b", i, clk_o, e_clk, ce_o, e_ce, pend_o, e_pend);
      end
    end
    load = 1'b0;
    sync = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_disabled();
    test_double_load();
    test_sync();
    test_load_sync();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
